// File: rtl/jstk_pkg.sv
// Shared constants, state encoding and TX frame layout for the PmodJSTK responder.
package jstk_pkg;
    localparam int         FRAME_LEN  = 40;
    localparam int         CNT_W      = 6;
    localparam logic [5:0] CMD_PREFIX = 6'b100000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_OVERRUN = 2'd2
    } state_t;

    // Byte order seen by the master: X lo, X hi, Y lo, Y hi, buttons.
    function automatic logic [FRAME_LEN-1:0] tx_frame(input logic [9:0] x,
                                                      input logic [9:0] y,
                                                      input logic [2:0] b);
        return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, b};
    endfunction
endpackage

// File: rtl/jstk_responder_if.sv
// SPI bus between the PmodJSTK master and the responder.
interface jstk_responder_if;
    logic SS;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS, output SCLK, output MOSI, input MISO);
    modport slave  (input SS, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/jstk_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
module jstk_sync_edge #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic [STAGES:0]   r_vld;
    logic              w_q;

    // Edges are suppressed until the chain and r_prev hold real samples, so a
    // line already away from its idle level at reset release is not an edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {STAGES{IDLE_VAL}};
            r_prev <= IDLE_VAL;
            r_vld  <= '0;
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= r_sync[STAGES-1];
            r_vld  <= {r_vld[STAGES-1:0], 1'b1};
        end
    end

    assign w_q    = r_sync[STAGES-1];
    assign o_rise = r_vld[STAGES] &  w_q & ~r_prev;
    assign o_fall = r_vld[STAGES] & ~w_q &  r_prev;
endmodule

// File: rtl/jstk_responder.sv
// SPI mode-0 responder emulating a PmodJSTK: streams position/buttons, decodes LED command.
module jstk_responder
    import jstk_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    jstk_responder_if.slave  spi,
    input  logic [9:0]       X_POS,
    input  logic [9:0]       Y_POS,
    input  logic [2:0]       BTNS,
    output logic [1:0]       LED_CMD,
    output logic             CMD_VALID,
    output logic             FRAME_DONE
);
    state_t               r_state, w_state_nxt;
    logic [FRAME_LEN-1:0] r_tx, w_tx_nxt;
    logic [FRAME_LEN-1:0] r_rx, w_rx_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [1:0]           r_led, w_led_nxt;
    logic                 r_cmd_vld, w_cmd_nxt;
    logic                 r_done, w_done_nxt;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                 w_ss_rise, w_ss_fall, w_sclk_rise, w_sclk_fall, w_mosi;

    jstk_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_ss (
        .i_clk(CLK), .i_rst(RST), .i_d(spi.SS), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );
    jstk_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk (
        .i_clk(CLK), .i_rst(RST), .i_d(spi.SCLK), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync[0] <= spi.MOSI;
            for (int i = 1; i < SYNC_STAGES; i++) r_mosi_sync[i] <= r_mosi_sync[i-1];
        end
    end
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_tx      <= '0;
            r_rx      <= '0;
            r_cnt     <= '0;
            r_led     <= 2'b00;
            r_cmd_vld <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx      <= w_tx_nxt;
            r_rx      <= w_rx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_led     <= w_led_nxt;
            r_cmd_vld <= w_cmd_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_rx_nxt    = r_rx;
        w_cnt_nxt   = r_cnt;
        w_led_nxt   = r_led;
        w_cmd_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_state_nxt = ST_SHIFT;
                    w_tx_nxt    = tx_frame(X_POS, Y_POS, BTNS);
                    w_rx_nxt    = '0;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                // SS edge wins over any SCLK edge seen in the same cycle.
                if (w_ss_rise) begin
                    w_state_nxt = ST_IDLE;
                    if (r_cnt == CNT_W'(FRAME_LEN)) begin
                        w_done_nxt = 1'b1;
                        if (r_rx[FRAME_LEN-1 -: 6] == CMD_PREFIX) begin
                            w_led_nxt = r_rx[FRAME_LEN-7 -: 2];
                            w_cmd_nxt = 1'b1;
                        end
                    end
                end else begin
                    if (w_sclk_rise) begin
                        if (r_cnt == CNT_W'(FRAME_LEN)) begin
                            w_state_nxt = ST_OVERRUN;
                        end else begin
                            w_rx_nxt  = {r_rx[FRAME_LEN-2:0], w_mosi};
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                    if (w_sclk_fall) w_tx_nxt = {r_tx[FRAME_LEN-2:0], 1'b0};
                end
            end
            ST_OVERRUN: begin
                if (w_ss_rise) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign spi.MISO   = (r_state == ST_SHIFT) & r_tx[FRAME_LEN-1];
    assign LED_CMD    = r_led;
    assign CMD_VALID  = r_cmd_vld;
    assign FRAME_DONE = r_done;
endmodule

// File: doc/jstk_responder.md
JSTK_RESPONDER -- requirements
Module: jstk_responder

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth applied to SS, SCLK and MOSI.
REQ-002 CLK  in  1  system clock; at least 8x the SCLK frequency.
REQ-003 RST  in  1  reset; one clock domain, asynchronous, active-high.
REQ-004 SS  in  1  SPI slave select, active low.
REQ-005 SCLK  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-006 MOSI  in  1  master-to-slave data, MSB first.
REQ-007 MISO  out  1  slave-to-master data, MSB first.
REQ-008 X_POS  in  10  emulated joystick X position.
REQ-009 Y_POS  in  10  emulated joystick Y position.
REQ-010 BTNS  in  3  button states {btn2, btn1, trigger}.
REQ-011 LED_CMD  out  2  LED bits from the last valid command.
REQ-012 CMD_VALID  out  1  one-CLK pulse when a valid command frame completes.
REQ-013 FRAME_DONE  out  1  one-CLK pulse when any full 40-bit frame completes.

Function
REQ-014 The module SHALL act as the SPI responder for the PmodJSTK master: 5-byte frames, 40 bits, MSB first.
REQ-015 SS, SCLK and MOSI SHALL pass through SYNC_STAGES flops before edge detection.
REQ-016 The FSM SHALL have three states:
- IDLE: waiting for SS to fall.
- SHIFT: frame in progress.
- OVERRUN: more than 40 SCLK rises seen in this frame.
REQ-017 The module SHALL move IDLE->SHIFT on a synchronized SS falling edge.
REQ-018 On that edge it SHALL load a 40-bit TX shift register with {X_POS[7:0], 6'b0, X_POS[9:8], Y_POS[7:0], 6'b0, Y_POS[9:8], 5'b0, BTNS}.
REQ-019 MISO SHALL present TX bit 39 within 1 CLK after the synchronized SS fall.
REQ-020 In SHIFT, each synchronized SCLK rise SHALL shift MOSI into a 40-bit RX register and increment a 6-bit bit counter.
REQ-021 In SHIFT, each synchronized SCLK fall SHALL shift the TX register so MISO shows the next bit.
REQ-022 TX and RX values SHALL be captured once per frame; changes to X_POS, Y_POS or BTNS mid-frame SHALL NOT affect the frame in progress.
REQ-023 When the bit counter reaches 40 and SS rises, the module SHALL go SHIFT->IDLE.
REQ-024 On that transition the module SHALL pulse FRAME_DONE for one CLK.
REQ-025 On that transition, if RX byte 0 bits [7:2] equal 6'b100000, LED_CMD SHALL load RX byte 0 bits [1:0] and CMD_VALID SHALL pulse in the same CLK.
REQ-026 If RX byte 0 does not match that pattern, LED_CMD SHALL hold its value and CMD_VALID SHALL stay low.
REQ-027 RX bytes 1-4 SHALL be ignored.
REQ-028 On a 41st SCLK rise the module SHALL go SHIFT->OVERRUN.
REQ-029 In OVERRUN, MISO SHALL be 0 and no pulses SHALL be produced; SS rising SHALL return to IDLE.
REQ-030 If SS rises with fewer than 40 bits (abort), the module SHALL return to IDLE with no FRAME_DONE, no CMD_VALID and LED_CMD unchanged.
REQ-031 While in IDLE, MISO SHALL be driven 0; it is not tri-stated.
REQ-032 If SCLK edges coincide with the SS edge in the same synchronized cycle, the SS edge SHALL take priority; the SCLK edge SHALL be ignored.
REQ-033 Latency from the raw SS rise to FRAME_DONE SHALL be SYNC_STAGES+1 CLK.

Reset
REQ-034 RST SHALL asynchronously force the following, regardless of the state of any frame in progress: state=IDLE, MISO=0, LED_CMD=2'b00, CMD_VALID=0, FRAME_DONE=0, bit counter=0, TX=0, RX=0, synchronizers=idle levels (SS=1, SCLK=0, MOSI=0).
REQ-035 After RST deasserts with SS low, the module SHALL wait for a fresh SS falling edge before starting a frame.

Structure
REQ-036 The frame length (40), command prefix (6'b100000) and state encodings SHALL reside in the shared jstk_pkg package.
REQ-037 One sub-module, jstk_sync_edge, SHALL hold a synchronizer plus rise/fall detector; it SHALL be instantiated for SS and SCLK, with MOSI using its sync output only.

Verification
REQ-038 X_POS=10'h2A5, Y_POS=10'h13C, BTNS=3'b101; master sends a 40-bit frame -> master receives 40'hA5_02_3C_01_05 and FRAME_DONE pulses once.
REQ-039 Master sends byte 0 = 8'b1000_0010 -> CMD_VALID pulses once and LED_CMD=2'b10.
REQ-040 Master sends byte 0 = 8'hFF -> FRAME_DONE pulses, CMD_VALID stays low, LED_CMD holds its prior value.
REQ-041 SS raised after 17 bits -> no pulses, LED_CMD unchanged; the next full frame is received correctly.
REQ-042 45 SCLK pulses in one frame -> MISO=0 after bit 40, no pulses; the next frame is correct.
REQ-043 RST asserted mid-frame at bit 20 -> all outputs go to reset values immediately; the frame after reset is correct.
